fp_regfile_sb: RTL and testbench

Parametrised floating-point register file with a per-register busy scoreboard, for the pipelined FPU datapath. It provides three bypassed read ports for fused multiply-add operands. Two write ports serve FPU writeback and FP load writeback. It also has a raw debug read port for the PDU. Issue logic marks destinations busy, writeback clears them, and a flush input drops all pending marks on a pipeline redirect.

---
 rtl/fp_regfile_sb_if.sv | 41 ++++
 rtl/fp_regfile_sb.sv | 96 +++++++++
 tb/tb_fp_regfile_sb.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_regfile_sb_if.sv
// Bus bundle for the FP register file: read, writeback, issue/flush and debug signals.
// The master side drives addresses, write data and strobes; the slave side is the register file.
interface fp_regfile_sb_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [WIDTH-1:0]  rd0;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic              busy0;
    logic              busy1;
    logic              busy2;
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [WIDTH-1:0]  wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [WIDTH-1:0]  wd1;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_rd;
    logic              flush;
    logic [ADDR_W-1:0] ra_dbg;
    logic [WIDTH-1:0]  rd_dbg;
    logic [ADDR_W:0]   busy_cnt;
    logic              wconf;

    modport master (
        output ra0, ra1, ra2, we0, wa0, wd0, we1, wa1, wd1,
               iss_en, iss_rd, flush, ra_dbg,
        input  rd0, rd1, rd2, busy0, busy1, busy2, rd_dbg, busy_cnt, wconf
    );

    modport slave (
        input  ra0, ra1, ra2, we0, wa0, wd0, we1, wa1, wd1,
               iss_en, iss_rd, flush, ra_dbg,
        output rd0, rd1, rd2, busy0, busy1, busy2, rd_dbg, busy_cnt, wconf
    );
endinterface

// File: rtl/fp_regfile_sb.sv
// FP register file with three bypassed read ports, two write ports and a per-register busy scoreboard.
// Port 0 (FPU writeback) wins address collisions against port 1 (load writeback).
module fp_regfile_sb #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input logic           clk,
    input logic           rst,
    fp_regfile_sb_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
    localparam int CW   = ADDR_W + 1;

    logic [WIDTH-1:0]  regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic [CW-1:0]     busy_cnt;
    logic              wconf;
    logic              collide;

    logic [ADDR_W-1:0] ra   [3];
    logic [WIDTH-1:0]  rd   [3];
    logic              bsy  [3];
    logic              hit0 [3];
    logic              hit1 [3];

    assign collide = bus.we0 & bus.we1 & (bus.wa0 == bus.wa1);

    assign ra[0] = bus.ra0;
    assign ra[1] = bus.ra1;
    assign ra[2] = bus.ra2;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hit0[i] = bus.we0 & (bus.wa0 == ra[i]);
            hit1[i] = bus.we1 & (bus.wa1 == ra[i]);
            if (hit0[i])
                rd[i] = bus.wd0;
            else if (hit1[i])
                rd[i] = bus.wd1;
            else
                rd[i] = regs[ra[i]];
            // a same-cycle writeback makes the operand ready
            bsy[i] = busy[ra[i]] & ~(hit0[i] | hit1[i]);
        end
    end

    assign bus.rd0    = rd[0];
    assign bus.rd1    = rd[1];
    assign bus.rd2    = rd[2];
    assign bus.busy0  = bsy[0];
    assign bus.busy1  = bsy[1];
    assign bus.busy2  = bsy[2];
    assign bus.rd_dbg = regs[bus.ra_dbg];
    assign bus.busy_cnt = busy_cnt;
    assign bus.wconf    = wconf;

    // flush > issue set > writeback clear > hold
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < NREG; r++) begin
            if (bus.flush)
                busy_nxt[r] = 1'b0;
            else if (bus.iss_en && (bus.iss_rd == ADDR_W'(r)))
                busy_nxt[r] = 1'b1;
            else if ((bus.we0 && (bus.wa0 == ADDR_W'(r))) ||
                     (bus.we1 && (bus.wa1 == ADDR_W'(r))))
                busy_nxt[r] = 1'b0;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREG; r++)
            cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                regs[r] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
            wconf    <= 1'b0;
        end else begin
            if (bus.we0)
                regs[bus.wa0] <= bus.wd0;
            if (bus.we1 && !collide)
                regs[bus.wa1] <= bus.wd1;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            wconf    <= collide;
        end
    end
endmodule

// File: tb/tb_fp_regfile_sb.sv
// Scoreboard bench for fp_regfile_sb: a driver pushes expected outputs from a behavioural model,
// a monitor pops and compares them on the falling edge.
module tb_fp_regfile_sb;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    typedef struct packed {
        logic        rst;
        logic [4:0]  ra0, ra1, ra2, ra_dbg;
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iss_en;
        logic [4:0]  iss_rd;
        logic        flush;
    } stim_t;

    typedef struct packed {
        int              cyc;
        logic [2:0][31:0] rd;
        logic [2:0]      bsy;
        logic [31:0]     rd_dbg;
        logic [5:0]      cnt;
        logic            wconf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    fp_regfile_sb_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    fp_regfile_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] m_regs [NREG];
    logic [31:0] m_busy;
    logic [5:0]  m_cnt;
    logic        m_wconf;
    exp_t        q [$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc_no = 0;

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input stim_t s, input logic [4:0] a);
        if (s.we0 && s.wa0 == a) return s.wd0;
        if (s.we1 && s.wa1 == a) return s.wd1;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input stim_t s, input logic [4:0] a);
        return m_busy[a] && !((s.we0 && s.wa0 == a) || (s.we1 && s.wa1 == a));
    endfunction

    // model of one clock edge, applied sequentially so later rules override earlier ones
    task automatic model_step(input stim_t s);
        logic col;
        if (s.rst) begin
            for (int r = 0; r < NREG; r++) m_regs[r] = '0;
            m_busy  = '0;
            m_cnt   = '0;
            m_wconf = 1'b0;
        end else begin
            col = s.we0 && s.we1 && (s.wa0 == s.wa1);
            if (s.we1) m_regs[s.wa1] = s.wd1;
            if (s.we0) m_regs[s.wa0] = s.wd0;
            if (s.we0) m_busy[s.wa0] = 1'b0;
            if (s.we1) m_busy[s.wa1] = 1'b0;
            if (s.iss_en) m_busy[s.iss_rd] = 1'b1;
            if (s.flush) m_busy = '0;
            m_cnt   = 6'($countones(m_busy));
            m_wconf = col;
        end
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = s.rst;
        bus.ra0      = s.ra0;
        bus.ra1      = s.ra1;
        bus.ra2      = s.ra2;
        bus.ra_dbg   = s.ra_dbg;
        bus.we0      = s.we0;
        bus.wa0      = s.wa0;
        bus.wd0      = s.wd0;
        bus.we1      = s.we1;
        bus.wa1      = s.wa1;
        bus.wd1      = s.wd1;
        bus.iss_en   = s.iss_en;
        bus.iss_rd   = s.iss_rd;
        bus.flush    = s.flush;
        e.cyc        = cyc_no;
        e.rd[0]      = exp_rd(s, s.ra0);
        e.rd[1]      = exp_rd(s, s.ra1);
        e.rd[2]      = exp_rd(s, s.ra2);
        e.bsy[0]     = exp_busy(s, s.ra0);
        e.bsy[1]     = exp_busy(s, s.ra1);
        e.bsy[2]     = exp_busy(s, s.ra2);
        e.rd_dbg     = m_regs[s.ra_dbg];
        e.cnt        = m_cnt;
        e.wconf      = m_wconf;
        q.push_back(e);
        model_step(s);
        cyc_no++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst    = ($urandom_range(0, 99) == 0);
        s.ra0    = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        s.ra1    = 5'($urandom_range(0, 7));
        s.ra2    = 5'($urandom_range(0, 31));
        s.ra_dbg = 5'($urandom_range(0, 7));
        s.we0    = 1'($urandom_range(0, 1));
        s.wa0    = 5'($urandom_range(0, 7));
        s.wd0    = $urandom;
        s.we1    = 1'($urandom_range(0, 1));
        s.wa1    = 5'($urandom_range(0, 7));
        s.wd1    = $urandom;
        s.iss_en = ($urandom_range(0, 2) == 0);
        s.iss_rd = 5'($urandom_range(0, 7));
        s.flush  = ($urandom_range(0, 19) == 0);
        return s;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                check("rd0",      e.cyc, bus.rd0,            e.rd[0]);
                check("rd1",      e.cyc, bus.rd1,            e.rd[1]);
                check("rd2",      e.cyc, bus.rd2,            e.rd[2]);
                check("busy0",    e.cyc, 32'(bus.busy0),     32'(e.bsy[0]));
                check("busy1",    e.cyc, 32'(bus.busy1),     32'(e.bsy[1]));
                check("busy2",    e.cyc, 32'(bus.busy2),     32'(e.bsy[2]));
                check("rd_dbg",   e.cyc, bus.rd_dbg,         e.rd_dbg);
                check("busy_cnt", e.cyc, 32'(bus.busy_cnt),  32'(e.cnt));
                check("wconf",    e.cyc, 32'(bus.wconf),     32'(e.wconf));
            end
        end
    end

    initial begin : driver
        stim_t s;
        s = idle();
        rst = 1'b1;
        {bus.ra0, bus.ra1, bus.ra2, bus.ra_dbg} = '0;
        {bus.we0, bus.wa0, bus.wd0, bus.we1, bus.wa1, bus.wd1} = '0;
        {bus.iss_en, bus.iss_rd, bus.flush} = '0;
        for (int r = 0; r < NREG; r++) m_regs[r] = '0;
        m_busy = '0; m_cnt = '0; m_wconf = 1'b0;
        repeat (2) @(posedge clk);

        // write f1 via port 0: bypass then array, debug port unbypassed
        s = idle(); s.we0 = 1; s.wa0 = 1; s.wd0 = 32'h3F80_0000; s.ra0 = 1; s.ra_dbg = 1;
        cyc(s);
        s = idle(); s.ra0 = 1; s.ra_dbg = 1;
        cyc(s);

        // issue f5, idle, load writeback clears it
        s = idle(); s.iss_en = 1; s.iss_rd = 5; s.ra1 = 5;
        cyc(s);
        s = idle(); s.ra1 = 5;
        cyc(s);
        s = idle(); s.we1 = 1; s.wa1 = 5; s.wd1 = 32'h4000_0000; s.ra1 = 5;
        cyc(s);
        s = idle(); s.ra1 = 5;
        cyc(s);

        // write collision on f3
        s = idle(); s.we0 = 1; s.wa0 = 3; s.wd0 = 32'hAAAA_AAAA;
        s.we1 = 1; s.wa1 = 3; s.wd1 = 32'h5555_5555; s.ra2 = 3;
        cyc(s);
        s = idle(); s.ra2 = 3; s.ra_dbg = 3;
        cyc(s);
        cyc(s);

        // issue and writeback to f7 in the same cycle
        s = idle(); s.iss_en = 1; s.iss_rd = 7; s.we0 = 1; s.wa0 = 7; s.wd0 = 32'h1234_5678; s.ra0 = 7;
        cyc(s);
        s = idle(); s.ra0 = 7; s.ra_dbg = 7;
        cyc(s);

        // three issues then flush with a competing issue
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.iss_en = 1; s.iss_rd = (i == 0) ? 5'd2 : (i == 1) ? 5'd4 : 5'd9;
            s.ra0 = 2; s.ra1 = 4; s.ra2 = 9;
            cyc(s);
        end
        s = idle(); s.flush = 1; s.iss_en = 1; s.iss_rd = 10; s.ra0 = 2; s.ra1 = 10; s.ra2 = 9;
        cyc(s);
        s = idle(); s.ra0 = 2; s.ra1 = 10; s.ra2 = 7;
        cyc(s);

        // fill every register, read them back, then reset with a write pending
        for (int i = 0; i < NREG; i++) begin
            s = idle(); s.we0 = 1; s.wa0 = 5'(i); s.wd0 = {16'hC0DE, 16'(i)};
            s.iss_en = 1; s.iss_rd = 5'(i);
            cyc(s);
        end
        for (int i = 0; i < NREG; i++) begin
            s = idle(); s.ra0 = 5'(i); s.ra1 = 5'(NREG - 1 - i); s.ra2 = 5'(i); s.ra_dbg = 5'(i);
            cyc(s);
        end
        s = idle(); s.rst = 1; s.we0 = 1; s.wa0 = 4; s.wd0 = 32'hDEAD_BEEF;
        s.iss_en = 1; s.iss_rd = 4; s.ra0 = 0; s.ra1 = 31; s.ra2 = 5;
        cyc(s);
        s = idle(); s.ra0 = 4; s.ra1 = 31; s.ra2 = 5; s.ra_dbg = 4;
        cyc(s);

        // randomized traffic
        for (int i = 0; i < 600; i++) cyc(rand_stim());

        s = idle();
        cyc(s);
        @(posedge clk);
        @(posedge clk);
        check("q_drain", cyc_no, 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
